// File: rtl/hazard_ctrl_v2_if.sv
// Hazard controller bundle: pipeline status from the core in, keep/flush/forward and status back out.
interface hazard_ctrl_v2_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              re1_id, re2_id;
    logic [REG_AW-1:0] rr1_id, rr2_id;
    logic              rf_we_ex, load_ex;
    logic [REG_AW-1:0] wr_ex;
    logic [XLEN-1:0]   wd_ex;
    logic              rf_we_mem;
    logic [REG_AW-1:0] wr_mem;
    logic [XLEN-1:0]   wd_mem;
    logic              rf_we_wb;
    logic [REG_AW-1:0] wr_wb;
    logic [XLEN-1:0]   wd_wb;
    logic              redirect_ex, mem_req, mem_ready;
    logic              keep_pc, keep_if_id, keep_id_ex, keep_ex_mem;
    logic              flush_if_id, flush_id_ex, flush_mem_wb;
    logic              fwd1_en, fwd2_en;
    logic [XLEN-1:0]   fwd1_data, fwd2_data;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output re1_id, re2_id, rr1_id, rr2_id, rf_we_ex, load_ex, wr_ex, wd_ex,
               rf_we_mem, wr_mem, wd_mem, rf_we_wb, wr_wb, wd_wb,
               redirect_ex, mem_req, mem_ready,
        input  keep_pc, keep_if_id, keep_id_ex, keep_ex_mem,
               flush_if_id, flush_id_ex, flush_mem_wb,
               fwd1_en, fwd1_data, fwd2_en, fwd2_data, mem_err, stall_cnt, flush_cnt
    );
    modport slave (
        input  re1_id, re2_id, rr1_id, rr2_id, rf_we_ex, load_ex, wr_ex, wd_ex,
               rf_we_mem, wr_mem, wd_mem, rf_we_wb, wr_wb, wd_wb,
               redirect_ex, mem_req, mem_ready,
        output keep_pc, keep_if_id, keep_id_ex, keep_ex_mem,
               flush_if_id, flush_id_ex, flush_mem_wb,
               fwd1_en, fwd1_data, fwd2_en, fwd2_data, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_v2.sv
// 5-stage RV32I hazard controller: ID operand forwarding/interlock, DRAM wait/timeout FSM,
// keep/flush generation and saturating stall/flush counters.
module hazard_ctrl_v2_opnd #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              re_i,
    input  logic [REG_AW-1:0] rr_i,
    input  logic              rf_we_ex_i,
    input  logic              load_ex_i,
    input  logic [REG_AW-1:0] wr_ex_i,
    input  logic [XLEN-1:0]   wd_ex_i,
    input  logic              rf_we_mem_i,
    input  logic [REG_AW-1:0] wr_mem_i,
    input  logic [XLEN-1:0]   wd_mem_i,
    input  logic              rf_we_wb_i,
    input  logic [REG_AW-1:0] wr_wb_i,
    input  logic [XLEN-1:0]   wd_wb_i,
    output logic              fwd_en_o,
    output logic [XLEN-1:0]   fwd_data_o,
    output logic              stall_o
);
    logic m_ex, m_mem, m_wb;

    // x0 is hardwired zero, so a write to it never creates a dependency
    assign m_ex  = re_i & rf_we_ex_i  & (wr_ex_i  != '0) & (wr_ex_i  == rr_i);
    assign m_mem = re_i & rf_we_mem_i & (wr_mem_i != '0) & (wr_mem_i == rr_i);
    assign m_wb  = re_i & rf_we_wb_i  & (wr_wb_i  != '0) & (wr_wb_i  == rr_i);

    always_comb begin
        fwd_en_o   = 1'b0;
        fwd_data_o = '0;
        stall_o    = 1'b0;
        if (FWD_EN) begin
            if (m_ex) begin
                if (load_ex_i) begin
                    stall_o = 1'b1;
                end else begin
                    fwd_en_o   = 1'b1;
                    fwd_data_o = wd_ex_i;
                end
            end else if (m_mem) begin
                fwd_en_o   = 1'b1;
                fwd_data_o = wd_mem_i;
            end else if (m_wb) begin
                fwd_en_o   = 1'b1;
                fwd_data_o = wd_wb_i;
            end
        end else begin
            stall_o = m_ex | m_mem | m_wb;
        end
    end
endmodule

module hazard_ctrl_v2 #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter bit FWD_EN      = 1'b1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic             clk,
    input logic             rst_n,
    hazard_ctrl_v2_if.slave hz
);
    localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic [1:0]                 re;
    logic [1:0][REG_AW-1:0]     rr;
    logic [1:0]                 op_fwd, op_stall;
    logic [1:0][XLEN-1:0]       op_data;

    assign re = {hz.re2_id, hz.re1_id};
    assign rr = {hz.rr2_id, hz.rr1_id};

    for (genvar i = 0; i < 2; i++) begin : g_opnd
        hazard_ctrl_v2_opnd #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_opnd (
            .re_i       (re[i]),
            .rr_i       (rr[i]),
            .rf_we_ex_i (hz.rf_we_ex),
            .load_ex_i  (hz.load_ex),
            .wr_ex_i    (hz.wr_ex),
            .wd_ex_i    (hz.wd_ex),
            .rf_we_mem_i(hz.rf_we_mem),
            .wr_mem_i   (hz.wr_mem),
            .wd_mem_i   (hz.wd_mem),
            .rf_we_wb_i (hz.rf_we_wb),
            .wr_wb_i    (hz.wr_wb),
            .wd_wb_i    (hz.wd_wb),
            .fwd_en_o   (op_fwd[i]),
            .fwd_data_o (op_data[i]),
            .stall_o    (op_stall[i])
        );
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = S_RUN;
                end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = S_ERR;
        endcase
    end

    logic err, mem_stall, redir, raw;

    assign err       = (state_q == S_ERR);
    assign mem_stall = ((state_q == S_RUN) & hz.mem_req & ~hz.mem_ready) |
                       ((state_q == S_WAIT) & ~hz.mem_ready);
    // A redirect held off by a memory stall stays asserted in EX and acts once the stall clears
    assign redir     = ~err & ~mem_stall & hz.redirect_ex;
    assign raw       = ~err & ~mem_stall & ~hz.redirect_ex & (|op_stall);

    assign hz.keep_pc      = rst_n & (err | mem_stall | raw);
    assign hz.keep_if_id   = rst_n & (err | mem_stall | raw);
    assign hz.keep_id_ex   = rst_n & (err | mem_stall);
    assign hz.keep_ex_mem  = rst_n & (err | mem_stall);
    assign hz.flush_if_id  = rst_n & redir;
    assign hz.flush_id_ex  = rst_n & (redir | raw);
    assign hz.flush_mem_wb = rst_n & (err | mem_stall);
    assign hz.fwd1_en      = rst_n & op_fwd[0];
    assign hz.fwd2_en      = rst_n & op_fwd[1];
    assign hz.fwd1_data    = rst_n ? op_data[0] : '0;
    assign hz.fwd2_data    = rst_n ? op_data[1] : '0;
    assign hz.mem_err      = mem_err_q;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_q | (state_d == S_ERR);
            if (hz.keep_pc && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (redir && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Directed bench: forwarding, load-use, x0, interlock mode, DRAM wait/redirect, timeout and reset.
module tb_hazard_ctrl_v2;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_v2_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) ia ();
    hazard_ctrl_v2_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) ib ();

    hazard_ctrl_v2 #(.XLEN(32), .REG_AW(5), .FWD_EN(1'b1), .MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .hz(ia.slave));
    hazard_ctrl_v2 #(.XLEN(32), .REG_AW(5), .FWD_EN(1'b0), .MEM_TIMEOUT(8), .CNT_W(32)) dut_nf (
        .clk(clk), .rst_n(rst_n), .hz(ib.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        ia.re1_id = 0; ia.re2_id = 0; ia.rr1_id = 0; ia.rr2_id = 0;
        ia.rf_we_ex = 0; ia.load_ex = 0; ia.wr_ex = 0; ia.wd_ex = 0;
        ia.rf_we_mem = 0; ia.wr_mem = 0; ia.wd_mem = 0;
        ia.rf_we_wb = 0; ia.wr_wb = 0; ia.wd_wb = 0;
        ia.redirect_ex = 0; ia.mem_req = 0; ia.mem_ready = 0;
        ib.re1_id = 0; ib.re2_id = 0; ib.rr1_id = 0; ib.rr2_id = 0;
        ib.rf_we_ex = 0; ib.load_ex = 0; ib.wr_ex = 0; ib.wd_ex = 0;
        ib.rf_we_mem = 0; ib.wr_mem = 0; ib.wd_mem = 0;
        ib.rf_we_wb = 0; ib.wr_wb = 0; ib.wd_wb = 0;
        ib.redirect_ex = 0; ib.mem_req = 0; ib.mem_ready = 0;
    endtask

    // advance to just after the next active edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        // outputs forced low while in reset even with hazards present
        ia.redirect_ex = 1; ia.mem_req = 1;
        ia.re1_id = 1; ia.rr1_id = 5; ia.rf_we_ex = 1; ia.wr_ex = 5; ia.wd_ex = 32'h55;
        @(negedge clk);
        chk("rst_keep_pc", ia.keep_pc, 0);
        chk("rst_flush_if_id", ia.flush_if_id, 0);
        chk("rst_fwd1_en", ia.fwd1_en, 0);
        chk("rst_mem_err", ia.mem_err, 0);
        chk("rst_stall_cnt", ia.stall_cnt, 0);
        clr();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // EX forwarding wins over MEM
        ia.re1_id = 1; ia.rr1_id = 5;
        ia.rf_we_ex = 1; ia.wr_ex = 5; ia.wd_ex = 32'h1234;
        ia.rf_we_mem = 1; ia.wr_mem = 5; ia.wd_mem = 32'hAAAA;
        ia.rf_we_wb = 1; ia.wr_wb = 5; ia.wd_wb = 32'hBBBB;
        #1;
        chk("fwd_ex_en", ia.fwd1_en, 1);
        chk("fwd_ex_data", ia.fwd1_data, 32'h1234);
        chk("fwd_ex_keep", ia.keep_pc, 0);
        ia.rf_we_ex = 0; #1;
        chk("fwd_mem_data", ia.fwd1_data, 32'hAAAA);
        ia.rf_we_mem = 0; #1;
        chk("fwd_wb_data", ia.fwd1_data, 32'hBBBB);
        chk("fwd2_idle", ia.fwd2_en, 0);

        // x0 never forwards
        clr();
        ia.re1_id = 1; ia.rr1_id = 0; ia.rf_we_ex = 1; ia.wr_ex = 0; ia.wd_ex = 32'hDEAD;
        #1;
        chk("x0_fwd1_en", ia.fwd1_en, 0);
        chk("x0_keep_pc", ia.keep_pc, 0);
        cyc();

        // load-use: one bubble then MEM forward
        clr();
        ia.load_ex = 1; ia.rf_we_ex = 1; ia.wr_ex = 7; ia.re2_id = 1; ia.rr2_id = 7;
        #1;
        chk("lu_keep_pc", ia.keep_pc, 1);
        chk("lu_keep_if_id", ia.keep_if_id, 1);
        chk("lu_flush_id_ex", ia.flush_id_ex, 1);
        chk("lu_keep_id_ex", ia.keep_id_ex, 0);
        chk("lu_fwd2_en", ia.fwd2_en, 0);
        cyc();
        ia.load_ex = 0; ia.rf_we_ex = 0; ia.rf_we_mem = 1; ia.wr_mem = 7; ia.wd_mem = 32'hCAFE;
        #1;
        chk("lu2_keep_pc", ia.keep_pc, 0);
        chk("lu2_fwd2_en", ia.fwd2_en, 1);
        chk("lu2_fwd2_data", ia.fwd2_data, 32'hCAFE);
        chk("lu2_stall_cnt", ia.stall_cnt, 1);

        // redirect drops a coincident load-use stall
        clr();
        ia.load_ex = 1; ia.rf_we_ex = 1; ia.wr_ex = 7; ia.re2_id = 1; ia.rr2_id = 7;
        ia.redirect_ex = 1;
        #1;
        chk("rd_flush_if_id", ia.flush_if_id, 1);
        chk("rd_flush_id_ex", ia.flush_id_ex, 1);
        chk("rd_keep_pc", ia.keep_pc, 0);
        cyc();
        clr();
        #1;
        chk("rd_flush_cnt", ia.flush_cnt, 1);

        // DRAM wait, 4 not-ready cycles
        ia.mem_req = 1; ia.mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dw_keep_ex_mem", ia.keep_ex_mem, 1);
            chk("dw_flush_mem_wb", ia.flush_mem_wb, 1);
            cyc();
        end
        ia.mem_ready = 1; #1;
        chk("dw_done_keep", ia.keep_ex_mem, 0);
        cyc();

        // same with a pending redirect: it acts only on the ready cycle
        ia.mem_ready = 0; ia.redirect_ex = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dwr_keep_ex_mem", ia.keep_ex_mem, 1);
            chk("dwr_flush_if_id", ia.flush_if_id, 0);
            cyc();
        end
        ia.mem_ready = 1; #1;
        chk("dwr_flush_if_id_rdy", ia.flush_if_id, 1);
        chk("dwr_keep_pc_rdy", ia.keep_pc, 0);
        cyc();
        clr();
        #1;
        chk("dwr_flush_cnt", ia.flush_cnt, 2);
        chk("dwr_stall_cnt", ia.stall_cnt, 9);

        // timeout: 1 entry cycle + 8 wait cycles, then sticky error
        ia.mem_req = 1; ia.mem_ready = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk($sformatf("to_mem_err_%0d", i), ia.mem_err, (i >= 9) ? 1 : 0);
        end
        ia.mem_req = 0; ia.mem_ready = 1; ia.redirect_ex = 1;
        #1;
        chk("err_keep_pc", ia.keep_pc, 1);
        chk("err_keep_ex_mem", ia.keep_ex_mem, 1);
        chk("err_flush_mem_wb", ia.flush_mem_wb, 1);
        chk("err_flush_if_id", ia.flush_if_id, 0);
        #1 rst_n = 1'b0; #1;
        chk("err_rst_mem_err", ia.mem_err, 0);
        chk("err_rst_stall_cnt", ia.stall_cnt, 0);
        clr();
        @(negedge clk); rst_n = 1'b1;
        cyc();

        // async reset in the middle of a wait returns to run
        ia.mem_req = 1; ia.mem_ready = 0;
        cyc(); cyc();
        #1 rst_n = 1'b0; #1;
        chk("wrst_stall_cnt", ia.stall_cnt, 0);
        ia.mem_req = 0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("wrst_keep_pc", ia.keep_pc, 0);
        cyc();

        // interlock mode: producer walks EX, MEM, WB -> 3 stall cycles
        clr();
        ib.re1_id = 1; ib.rr1_id = 3; ib.rf_we_ex = 1; ib.wr_ex = 3; ib.wd_ex = 32'h77;
        #1;
        chk("nf_ex_keep_pc", ib.keep_pc, 1);
        chk("nf_ex_flush_id_ex", ib.flush_id_ex, 1);
        chk("nf_ex_fwd1_en", ib.fwd1_en, 0);
        cyc();
        ib.rf_we_ex = 0; ib.rf_we_mem = 1; ib.wr_mem = 3; #1;
        chk("nf_mem_keep_pc", ib.keep_pc, 1);
        cyc();
        ib.rf_we_mem = 0; ib.rf_we_wb = 1; ib.wr_wb = 3; #1;
        chk("nf_wb_keep_pc", ib.keep_pc, 1);
        cyc();
        ib.rf_we_wb = 0; #1;
        chk("nf_done_keep_pc", ib.keep_pc, 0);
        chk("nf_stall_cnt", ib.stall_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
